// File: rtl/sram_wb_target_pkg.sv
// Shared constants, timing helpers and state encoding for the SRAM Wishbone target.
package sram_wb_target_pkg;

   localparam int SYS_CLOCK_MHZ  = 64;
   localparam int WB_ADDR_WIDTH  = 20;
   localparam int DATA_WIDTH     = 8;
   localparam int RAM_ADDR_WIDTH = 17;

   // Datasheet limits of the external 128K x 8 asynchronous SRAM.
   localparam int SRAM_T_AA_NS = 55;   // address/OE access time
   localparam int SRAM_T_WP_NS = 45;   // minimum write pulse width

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      SETUP = 3'd2,
      PULSE = 3'd3,
      HOLD  = 3'd4,
      ACK   = 3'd5
   } sram_state_t;

   // Round a nanosecond limit up to whole system clocks so timing rescales with SYS_CLOCK_MHZ.
   function automatic int ns_to_cycles(input int ns);
      return (ns * SYS_CLOCK_MHZ + 999) / 1000;
   endfunction

endpackage

// File: rtl/sram_wb_target_if.sv
// Wishbone B4 pipelined single-beat bus between the SPI initiator and the SRAM target.
interface sram_wb_target_if;
   import sram_wb_target_pkg::*;

   logic [WB_ADDR_WIDTH-1:0] adr;
   logic [DATA_WIDTH-1:0]    dat_w;   // initiator -> target write data
   logic [DATA_WIDTH-1:0]    dat_r;   // target -> initiator read data
   logic                     we;
   logic                     cyc;
   logic                     stb;
   logic                     stall;
   logic                     ack;

   modport master (output adr, dat_w, we, cyc, stb, input dat_r, stall, ack);
   modport slave  (input adr, dat_w, we, cyc, stb, output dat_r, stall, ack);

endinterface

// File: rtl/sram_wb_target.sv
// Wishbone responder that turns each accepted single-beat request into a timed
// access on an asynchronous 128K x 8 SRAM and returns one ack pulse.
// READ_CYCLES and WRITE_CYCLES are legal from 1 to 15 (4-bit down-counter).
module sram_wb_target
   import sram_wb_target_pkg::*;
#(
   parameter int READ_CYCLES  = ns_to_cycles(SRAM_T_AA_NS),
   parameter int WRITE_CYCLES = ns_to_cycles(SRAM_T_WP_NS)
) (
   input  logic                      clock_i,
   input  logic                      reset_ni,
   sram_wb_target_if.slave           wb,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
   input  logic [DATA_WIDTH-1:0]     ram_data_i,
   output logic [DATA_WIDTH-1:0]     ram_data_o,
   output logic                      ram_data_oe_o,
   output logic                      ram_ce_n_o,
   output logic                      ram_oe_n_o,
   output logic                      ram_we_n_o
);

   localparam logic [3:0] READ_LOAD  = 4'(READ_CYCLES - 1);
   localparam logic [3:0] WRITE_LOAD = 4'(WRITE_CYCLES - 1);

   sram_state_t               r_state;
   logic [3:0]                r_cnt;
   logic                      r_lost;     // cyc_i dropped at some point during this access
   logic                      r_stall;
   logic                      r_ack;
   logic [DATA_WIDTH-1:0]     r_dat;
   logic [RAM_ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0]     r_wdat;
   logic                      r_data_oe;
   logic                      r_ce_n;
   logic                      r_oe_n;
   logic                      r_we_n;

   logic w_accept;
   logic w_cyc_lost;
   logic w_unused_adr;

   assign w_accept     = wb.cyc & wb.stb & ~r_stall;
   assign w_cyc_lost   = r_lost | ~wb.cyc;
   // Bits above the SRAM size are decoded upstream and deliberately ignored here.
   assign w_unused_adr = ^wb.adr[WB_ADDR_WIDTH-1:RAM_ADDR_WIDTH];

   assign wb.stall      = r_stall;
   assign wb.ack        = r_ack;
   assign wb.dat_r      = r_dat;
   assign ram_addr_o    = r_addr;
   assign ram_data_o    = r_wdat;
   assign ram_data_oe_o = r_data_oe;
   assign ram_ce_n_o    = r_ce_n;
   assign ram_oe_n_o    = r_oe_n;
   assign ram_we_n_o    = r_we_n;

   // Access sequencer: state, shared down-counter and every registered bus/pad output.
   always_ff @(posedge clock_i) begin
      if (!reset_ni) begin
         r_state   <= IDLE;
         r_cnt     <= 4'd0;
         r_lost    <= 1'b0;
         r_stall   <= 1'b0;
         r_ack     <= 1'b0;
         r_dat     <= {DATA_WIDTH{1'b0}};
         r_addr    <= {RAM_ADDR_WIDTH{1'b0}};
         r_wdat    <= {DATA_WIDTH{1'b0}};
         r_data_oe <= 1'b0;
         r_ce_n    <= 1'b1;
         r_oe_n    <= 1'b1;
         r_we_n    <= 1'b1;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_addr  <= wb.adr[RAM_ADDR_WIDTH-1:0];
                  r_wdat  <= wb.dat_w;
                  r_stall <= 1'b1;
                  r_lost  <= 1'b0;
                  r_state <= wb.we ? SETUP : READ;
               end else begin
                  r_stall <= 1'b0;
               end
            end
            READ: begin
               r_lost <= w_cyc_lost;
               if (r_oe_n) begin
                  // First READ clock: open the SRAM outputs and start the access timer.
                  r_ce_n <= 1'b0;
                  r_oe_n <= 1'b0;
                  r_cnt  <= READ_LOAD;
               end else if (r_cnt == 4'd0) begin
                  r_dat   <= ram_data_i;
                  r_ce_n  <= 1'b1;
                  r_oe_n  <= 1'b1;
                  r_ack   <= ~w_cyc_lost;
                  r_state <= ACK;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            SETUP: begin
               r_lost <= w_cyc_lost;
               if (r_ce_n) begin
                  // Address/data setup clock before WE falls.
                  r_ce_n    <= 1'b0;
                  r_data_oe <= 1'b1;
               end else begin
                  r_we_n  <= 1'b0;
                  r_cnt   <= WRITE_LOAD;
                  r_state <= PULSE;
               end
            end
            PULSE: begin
               r_lost <= w_cyc_lost;
               if (r_cnt == 4'd0) begin
                  r_we_n  <= 1'b1;
                  r_state <= HOLD;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            HOLD: begin
               // Data stayed driven one clock past the WE rising edge.
               r_ce_n    <= 1'b1;
               r_data_oe <= 1'b0;
               r_ack     <= ~w_cyc_lost;
               r_state   <= ACK;
            end
            ACK: begin
               r_stall <= 1'b0;
               r_lost  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state   <= IDLE;
               r_stall   <= 1'b0;
               r_data_oe <= 1'b0;
               r_ce_n    <= 1'b1;
               r_oe_n    <= 1'b1;
               r_we_n    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_wb_target.sv
// Directed self-checking bench for sram_wb_target with a behavioural 128K x 8 SRAM.
`timescale 1ns/1ps
module tb_sram_wb_target;
   import sram_wb_target_pkg::*;

   logic        clk = 1'b0;
   logic        reset_ni = 1'b0;
   logic [16:0] ram_addr_o;
   logic [7:0]  ram_data_i = 8'h00;
   logic [7:0]  ram_data_o;
   logic        ram_data_oe_o, ram_ce_n_o, ram_oe_n_o, ram_we_n_o;
   logic [7:0]  mem [0:131071];

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      int          accept_ok;
      int          ack_k;
      int          ack_cnt;
      int          oe_low;
      int          we_low;
      int          setup;
      int          oe_drop_k;
      int          we_rise_k;
      int          stable_err;
      int          idle_k;
      logic [16:0] addr_seen;
      logic [7:0]  dat_at_ack;
   } meas_t;

   sram_wb_target_if bus();

   sram_wb_target dut (
      .clock_i      (clk),
      .reset_ni     (reset_ni),
      .wb           (bus),
      .ram_addr_o   (ram_addr_o),
      .ram_data_i   (ram_data_i),
      .ram_data_o   (ram_data_o),
      .ram_data_oe_o(ram_data_oe_o),
      .ram_ce_n_o   (ram_ce_n_o),
      .ram_oe_n_o   (ram_oe_n_o),
      .ram_we_n_o   (ram_we_n_o)
   );

   // 64 MHz system clock.
   always #7.8125 clk = ~clk;

   // SRAM read path: data becomes valid 55 ns after OE falls, if the chip is still selected.
   initial begin
      forever begin
         @(negedge ram_oe_n_o);
         #55;
         if (!ram_oe_n_o && !ram_ce_n_o) ram_data_i = mem[ram_addr_o];
         else ram_data_i = 8'h00;
         if (!ram_oe_n_o) @(posedge ram_oe_n_o);
         ram_data_i = 8'h00;
      end
   end

   // Issue one request and record the pad/bus behaviour for 12 clocks after the accept edge.
   task automatic do_access(input logic we, input logic [19:0] adr, input logic [7:0] dat,
                            input int drop_k, output meas_t m);
      logic prev_we_n, prev_oe;
      logic [16:0] ref_a;
      logic [7:0]  ref_d;
      m = '0;
      ref_a = '0;
      ref_d = '0;
      @(negedge clk);
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we; bus.adr = adr; bus.dat_w = dat;
      @(posedge clk);
      @(negedge clk);
      bus.stb = 1'b0;
      m.accept_ok = (bus.stall === 1'b1) ? 1 : 0;
      prev_we_n = ram_we_n_o;
      prev_oe   = ram_data_oe_o;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == drop_k) bus.cyc = 1'b0;
         if (!ram_oe_n_o) begin m.oe_low++; m.addr_seen = ram_addr_o; end
         if (!ram_we_n_o) begin
            if (m.we_low == 0) begin ref_a = ram_addr_o; ref_d = ram_data_o; end
            else if (ram_addr_o !== ref_a || ram_data_o !== ref_d || ram_data_oe_o !== 1'b1) m.stable_err++;
            m.we_low++;
            m.addr_seen = ram_addr_o;
         end
         if (!ram_ce_n_o && ram_we_n_o && ram_data_oe_o && m.we_low == 0) m.setup++;
         if (!prev_we_n && ram_we_n_o) begin
            m.we_rise_k = k;
            if (!ram_ce_n_o && ram_data_oe_o) mem[ram_addr_o] = ram_data_o;
         end
         if (prev_oe && !ram_data_oe_o) m.oe_drop_k = k;
         if (bus.ack) begin
            m.ack_cnt++;
            if (m.ack_k == 0) m.ack_k = k;
            m.dat_at_ack = bus.dat_r;
         end
         if (!bus.stall && m.idle_k == 0) m.idle_k = k;
         prev_we_n = ram_we_n_o;
         prev_oe   = ram_data_oe_o;
      end
      bus.cyc = 1'b0;
   endtask

   task automatic test_reset();
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 20'h00010; bus.dat_w = 8'h00;
      reset_ni = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({ram_ce_n_o, ram_oe_n_o, ram_we_n_o} !== 3'b111) begin
         n_fail++; $display("FAIL reset_strobes: got %b want 111", {ram_ce_n_o, ram_oe_n_o, ram_we_n_o});
      end
      n_checks++;
      if ({bus.stall, bus.ack, ram_data_oe_o} !== 3'b000) begin
         n_fail++; $display("FAIL reset_bus: stall/ack/data_oe got %b want 000", {bus.stall, bus.ack, ram_data_oe_o});
      end
      n_checks++;
      if (ram_addr_o !== 17'h0 || ram_data_o !== 8'h00 || bus.dat_r !== 8'h00) begin
         n_fail++; $display("FAIL reset_data: addr %h data %h dat_o %h want 0", ram_addr_o, ram_data_o, bus.dat_r);
      end
      reset_ni = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.stb = 1'b0;
      n_checks++;
      if (bus.stall !== 1'b1) begin
         n_fail++; $display("FAIL reset_release_accept: stall got %b want 1", bus.stall);
      end
      begin
         int w;
         w = 0;
         while (bus.stall !== 1'b0 && w < 20) begin @(negedge clk); w++; end
         n_checks++;
         if (w >= 20) begin n_fail++; $display("FAIL reset_release_done: stall got %b want 0 within 20 clocks", bus.stall); end
      end
      bus.cyc = 1'b0;
   endtask

   task automatic test_read();
      meas_t m;
      do_access(1'b0, 20'h12345, 8'h00, 0, m);
      n_checks++;
      if (m.addr_seen !== 17'h12345) begin n_fail++; $display("FAIL read_addr: got %h want 12345", m.addr_seen); end
      n_checks++;
      if (m.oe_low !== 4) begin n_fail++; $display("FAIL read_oe_low: got %0d want 4", m.oe_low); end
      n_checks++;
      if (m.ack_k !== 5 || m.ack_cnt !== 1) begin
         n_fail++; $display("FAIL read_ack: at %0d count %0d want at 5 count 1", m.ack_k, m.ack_cnt);
      end
      n_checks++;
      if (m.dat_at_ack !== 8'hA5) begin n_fail++; $display("FAIL read_data: got %h want a5", m.dat_at_ack); end
      n_checks++;
      if (m.idle_k !== 6) begin n_fail++; $display("FAIL read_idle: stall low at %0d want 6", m.idle_k); end
   endtask

   task automatic test_write();
      meas_t m;
      do_access(1'b1, 20'h000FF, 8'h3C, 0, m);
      n_checks++;
      if (m.setup !== 1) begin n_fail++; $display("FAIL write_setup: got %0d want 1", m.setup); end
      n_checks++;
      if (m.we_low !== 3 || m.stable_err !== 0) begin
         n_fail++; $display("FAIL write_pulse: we_low %0d unstable %0d want 3 and 0", m.we_low, m.stable_err);
      end
      n_checks++;
      if (m.addr_seen !== 17'h000FF) begin n_fail++; $display("FAIL write_addr: got %h want 000ff", m.addr_seen); end
      n_checks++;
      if (m.oe_drop_k - m.we_rise_k !== 1) begin
         n_fail++; $display("FAIL write_hold: data_oe drop %0d we rise %0d want gap 1", m.oe_drop_k, m.we_rise_k);
      end
      n_checks++;
      if (m.ack_k !== 6 || m.ack_cnt !== 1) begin
         n_fail++; $display("FAIL write_ack: at %0d count %0d want at 6 count 1", m.ack_k, m.ack_cnt);
      end
      n_checks++;
      if (m.oe_low !== 0) begin n_fail++; $display("FAIL write_no_oe: oe low %0d clocks want 0", m.oe_low); end
      n_checks++;
      if (bus.dat_r !== 8'hA5) begin n_fail++; $display("FAIL write_keeps_dat_o: got %h want a5", bus.dat_r); end
      do_access(1'b0, 20'h000FF, 8'h00, 0, m);
      n_checks++;
      if (m.dat_at_ack !== 8'h3C) begin n_fail++; $display("FAIL write_readback: got %h want 3c", m.dat_at_ack); end
   endtask

   task automatic test_back_to_back();
      int acc, acks, acc2_k, segs, gap, hi_run, k;
      logic pend, prev_ce_n;
      logic [7:0] dat2;
      acc = 0; acks = 0; acc2_k = -1; segs = 0; gap = -1; hi_run = 0; dat2 = 8'h00;
      @(negedge clk);
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 20'h00100; bus.dat_w = 8'h77;
      pend = !bus.stall;
      prev_ce_n = ram_ce_n_o;
      for (k = 0; k < 20; k++) begin
         logic prev_we_n;
         prev_we_n = ram_we_n_o;
         @(posedge clk);
         @(negedge clk);
         if (pend) begin
            acc++;
            if (acc == 1) begin bus.we = 1'b0; bus.dat_w = 8'h00; end
            else begin bus.stb = 1'b0; acc2_k = k; end
         end
         if (!prev_we_n && ram_we_n_o && !ram_ce_n_o && ram_data_oe_o) mem[ram_addr_o] = ram_data_o;
         if (!ram_ce_n_o && prev_ce_n) begin
            segs++;
            if (segs == 2) gap = hi_run;
         end
         hi_run = ram_ce_n_o ? hi_run + 1 : 0;
         if (bus.ack) begin acks++; dat2 = bus.dat_r; end
         prev_ce_n = ram_ce_n_o;
         pend = bus.cyc && bus.stb && !bus.stall;
      end
      bus.cyc = 1'b0;
      n_checks++;
      if (acc !== 2 || acc2_k !== 8) begin
         n_fail++; $display("FAIL b2b_accept: accepts %0d second at %0d want 2 at 8", acc, acc2_k);
      end
      n_checks++;
      if (acks !== 2) begin n_fail++; $display("FAIL b2b_acks: got %0d want 2", acks); end
      n_checks++;
      if (segs !== 2 || gap < 1) begin
         n_fail++; $display("FAIL b2b_ce_gap: segments %0d gap %0d want 2 and >=1", segs, gap);
      end
      n_checks++;
      if (dat2 !== 8'h77) begin n_fail++; $display("FAIL b2b_read_data: got %h want 77", dat2); end
   endtask

   task automatic test_upper_bits();
      meas_t m;
      do_access(1'b0, 20'hFFFFF, 8'h00, 0, m);
      n_checks++;
      if (m.addr_seen !== 17'h1FFFF) begin n_fail++; $display("FAIL upper_read_addr: got %h want 1ffff", m.addr_seen); end
      n_checks++;
      if (m.dat_at_ack !== 8'h96) begin n_fail++; $display("FAIL upper_read_data: got %h want 96", m.dat_at_ack); end
      do_access(1'b1, 20'hE0003, 8'hE1, 0, m);
      n_checks++;
      if (m.addr_seen !== 17'h00003 || mem[3] !== 8'hE1) begin
         n_fail++; $display("FAIL upper_write: addr %h mem %h want 00003 and e1", m.addr_seen, mem[3]);
      end
   endtask

   task automatic test_cyc_drop();
      meas_t m;
      do_access(1'b1, 20'h00400, 8'hC3, 3, m);
      n_checks++;
      if (m.we_low !== 3) begin n_fail++; $display("FAIL drop_we_low: got %0d want 3", m.we_low); end
      n_checks++;
      if (m.ack_cnt !== 0) begin n_fail++; $display("FAIL drop_no_ack: got %0d acks want 0", m.ack_cnt); end
      n_checks++;
      if (m.idle_k !== 7) begin n_fail++; $display("FAIL drop_idle: stall low at %0d want 7", m.idle_k); end
      n_checks++;
      if (mem[17'h00400] !== 8'hC3) begin n_fail++; $display("FAIL drop_mem: got %h want c3", mem[17'h00400]); end
   endtask

   task automatic test_reset_mid_read();
      @(negedge clk);
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 20'h00020;
      @(posedge clk);
      @(negedge clk);
      bus.stb = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (ram_oe_n_o !== 1'b0) begin n_fail++; $display("FAIL midread_oe_active: got %b want 0", ram_oe_n_o); end
      reset_ni = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({ram_oe_n_o, ram_ce_n_o, bus.stall, bus.ack} !== 4'b1100) begin
         n_fail++; $display("FAIL midread_reset: oe_n/ce_n/stall/ack got %b want 1100",
                            {ram_oe_n_o, ram_ce_n_o, bus.stall, bus.ack});
      end
      reset_ni = 1'b1;
      bus.cyc = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.adr = 20'h0; bus.dat_w = 8'h0;
      for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
      mem[17'h12345] = 8'hA5;
      mem[17'h1FFFF] = 8'h96;
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_upper_bits();
      test_cyc_drop();
      test_reset_mid_read();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
